if_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the CPU core and supplies its `instr` stream. It holds the program counter and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered in a small prefetch FIFO and presented to decode with valid/ready. Branch/jump redirects from the core flush the buffer and discard in-flight responses.

---
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Handshake bundle between the instruction fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode/core side.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, prefetch FIFO, redirect flush.
// Optional stall counter port perf_stall_cnt is built when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt
`endif
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam int         CW      = AW + 1;
    localparam logic [1:0] AQ_LAST = 2'(MAX_OUTST - 1);

    function automatic logic [1:0] aq_inc(input logic [1:0] p);
        return (p == AQ_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    logic [31:0]   pc_r;
    logic [1:0]    outst_r;
    logic [1:0]    disc_r;
    logic [1:0]    aq_wr_r;
    logic [1:0]    aq_rd_r;
    logic [31:0]   aq_mem_r     [0:3];
    logic [31:0]   fifo_instr_r [0:FIFO_DEPTH-1];
    logic [31:0]   fifo_pc_r    [0:FIFO_DEPTH-1];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] fifo_cnt_r;

    logic [15:0]   inflight_s;
    logic          imem_req_s;
    logic          accept_s;
    logic          resp_s;
    logic          resp_take_s;
    logic          resp_drop_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_nonempty_s;
    logic          unused_ok_s;

    // Every in-flight request, live or stale, holds a credit until its response returns.
    assign inflight_s      = 16'(outst_r) + 16'(disc_r);
    assign fifo_nonempty_s = (fifo_cnt_r != {CW{1'b0}});
    assign imem_req_s      = rst_n & ~bus.halt & ~bus.redirect_valid
                           & ((16'(fifo_cnt_r) + inflight_s) < 16'(FIFO_DEPTH))
                           & (inflight_s < 16'(MAX_OUTST));
    assign accept_s        = imem_req_s & bus.imem_gnt;
    assign resp_s          = bus.imem_rvalid & (inflight_s != 16'd0);
    assign resp_drop_s     = resp_s & (disc_r != 2'd0);
    assign resp_take_s     = resp_s & (disc_r == 2'd0);
    assign push_s          = resp_take_s & ~bus.redirect_valid;
    assign pop_s           = fifo_nonempty_s & bus.instr_ready & ~bus.redirect_valid;
    assign unused_ok_s     = ^bus.redirect_pc[1:0];

    assign bus.imem_req    = imem_req_s;
    assign bus.imem_addr   = pc_r;
    assign bus.instr_valid = fifo_nonempty_s;
    assign bus.instr       = fifo_instr_r[rd_ptr_r];
    assign bus.instr_pc    = fifo_pc_r[rd_ptr_r];

    // PC, outstanding/discard accounting and the address queue of accepted requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            outst_r <= 2'd0;
            disc_r  <= 2'd0;
            aq_wr_r <= 2'd0;
            aq_rd_r <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                aq_mem_r[i] <= 32'h0000_0000;
            end
        end else if (bus.redirect_valid) begin
            // A same-cycle response retires the oldest in-flight request, live or stale.
            pc_r    <= {bus.redirect_pc[31:2], 2'b00};
            disc_r  <= disc_r + outst_r - {1'b0, resp_s};
            outst_r <= 2'd0;
            aq_wr_r <= 2'd0;
            aq_rd_r <= 2'd0;
        end else begin
            if (accept_s) begin
                pc_r              <= pc_r + 32'd4;
                aq_mem_r[aq_wr_r] <= pc_r;
                aq_wr_r           <= aq_inc(aq_wr_r);
            end
            if (resp_take_s) begin
                aq_rd_r <= aq_inc(aq_rd_r);
            end
            outst_r <= outst_r + {1'b0, accept_s} - {1'b0, resp_take_s};
            disc_r  <= disc_r - {1'b0, resp_drop_s};
        end
    end

    // Prefetch FIFO: response words in, decode pops out, flushed on redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= 32'h0000_0000;
            end
        end else if (bus.redirect_valid) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
                fifo_pc_r[wr_ptr_r]    <= aq_mem_r[aq_rd_r];
                wr_ptr_r               <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_r;

    // Saturating count of cycles where decode is starved while fetch is not halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_r <= 32'h0000_0000;
        end else if (!fifo_nonempty_s && !bus.halt && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_stall_cnt = perf_r;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic against
// a queue-based reference model (in-flight request queue with stale tags, output queue).
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUTST  = 2;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gnt, rvalid, ready, redir, halt;
    logic [31:0] rdata, redir_pc;
    logic [31:0] perf;

    if_fetch_unit_if bus ();
    assign bus.imem_gnt       = gnt;
    assign bus.imem_rvalid    = rvalid;
    assign bus.imem_rdata     = rdata;
    assign bus.instr_ready    = ready;
    assign bus.redirect_valid = redir;
    assign bus.redirect_pc    = redir_pc;
    assign bus.halt           = halt;

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf)
`endif
    );

`ifndef IF_PERF_CNT_EN
    assign perf = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat_min, lat_max, stall_pct, stray_pct;
    req_t        q[$];
    ent_t        outq[$];
    logic [31:0] m_pc;
    logic [31:0] m_perf;
    bit          m_req;
    bit          m_starved;
    bit          ok;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        outq.delete();
        m_pc   = RESET_PC;
        m_perf = 32'h0;
    endtask

    task automatic drive_mem();
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (rst_n && q.size() > 0) begin
            if (q[0].due <= cyc && $urandom_range(99) >= stall_pct) begin
                rvalid = 1'b1;
                rdata  = mem_fn(q[0].pc);
            end
        end else if (rst_n && $urandom_range(99) < stray_pct) begin
            rvalid = 1'b1;
            rdata  = $urandom;
        end
    endtask

    task automatic check();
        m_req = rst_n && !halt && !redir
             && (outq.size() + q.size() < FIFO_DEPTH) && (q.size() < MAX_OUTST);
        m_starved = (outq.size() == 0);
        chk("imem_req", {31'h0, bus.imem_req}, {31'h0, m_req});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_valid", {31'h0, bus.instr_valid}, {31'h0, !m_starved});
        if (!m_starved) begin
            chk("instr", bus.instr, outq[0].ins);
            chk("instr_pc", bus.instr_pc, outq[0].pc);
        end
`ifdef IF_PERF_CNT_EN
        chk("perf_stall_cnt", perf, m_perf);
`endif
    endtask

    task automatic update();
        req_t e;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_starved && !halt && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
            if (redir) begin
                outq.delete();
                if (rvalid && q.size() > 0) void'(q.pop_front());
                foreach (q[i]) q[i].stale = 1'b1;
                m_pc = {redir_pc[31:2], 2'b00};
            end else begin
                bit push = 1'b0;
                if (rvalid && q.size() > 0) begin
                    e = q.pop_front();
                    push = !e.stale;
                end
                if (!m_starved && ready) void'(outq.pop_front());
                if (push) outq.push_back('{pc: e.pc, ins: mem_fn(e.pc)});
            end
            if (m_req && gnt) begin
                q.push_back('{pc: m_pc, stale: 1'b0, due: cyc + $urandom_range(lat_max, lat_min)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        drive_mem();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        cyc++;
        #1;
    endtask

    task automatic rand_inputs();
        gnt      = ($urandom_range(99) < 70);
        ready    = ($urandom_range(99) < 70);
        if ($urandom_range(99) < 5) halt = ~halt;
        redir    = ($urandom_range(99) < 4);
        redir_pc = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; gnt = 1'b0; ready = 1'b0; halt = 1'b0; redir = 1'b0;
        redir_pc = 32'h0; rvalid = 1'b0; rdata = 32'h0;
        lat_min = 1; lat_max = 1; stall_pct = 0; stray_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_addr", bus.imem_addr, RESET_PC);

        // 1-cycle memory, always granted, decode always ready
        rst_n = 1'b1; gnt = 1'b1; ready = 1'b1;
        repeat (20) tick();

        // Decode stalls: FIFO fills, requests stop, nothing lost on resume
        ready = 1'b0;
        repeat (12) tick();
        chk("full_req_low", {31'h0, bus.imem_req}, 32'h0);
        ready = 1'b1;
        repeat (10) tick();

        // 3-cycle memory, redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 2) begin ok = 1'b1; break; end
            tick();
        end
        chk("wait_two_outst", {31'h0, ok}, 32'h1);
        redir = 1'b1; redir_pc = 32'h0000_0400;
        tick();
        redir = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (outq.size() > 0) begin ok = 1'b1; break; end
            tick();
        end
        chk("wait_redir400", {31'h0, ok}, 32'h1);
        chk("redir400_first", bus.instr_pc, 32'h0000_0400);
        repeat (5) tick();

        // Redirect to unaligned target concurrent with pop and response
        lat_min = 1; lat_max = 1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (outq.size() > 0 && q.size() > 0 && q[0].due <= cyc) begin ok = 1'b1; break; end
            tick();
        end
        chk("wait_concurrent", {31'h0, ok}, 32'h1);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        tick();
        redir = 1'b0;
        chk("redir_flush_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("redir_target", bus.imem_addr, 32'h0000_0100);
        repeat (8) tick();

        // Halt with one request outstanding
        lat_min = 3; lat_max = 3; gnt = 1'b0;
        repeat (6) tick();
        gnt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 1) begin ok = 1'b1; break; end
            tick();
        end
        chk("wait_one_outst", {31'h0, ok}, 32'h1);
        halt = 1'b1;
        repeat (8) tick();
        chk("halt_no_req", {31'h0, bus.imem_req}, 32'h0);
        halt = 1'b0;
        repeat (8) tick();

        // Randomized traffic
        lat_min = 1; lat_max = 3; stall_pct = 20; stray_pct = 10;
        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            tick();
        end

        // Reset in the middle of traffic
        redir = 1'b0; halt = 1'b0; rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("midrst_addr", bus.imem_addr, RESET_PC);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
